// File: rtl/b_cache_wr_seq_pkg.sv
// Shared definitions for the B-cache write sequencer and the B-cache din mapper.
// Holds the operation encodings, the mapper select codes, and the per-op
// sequence length, write window and pipeline depth.
package b_cache_wr_seq_pkg;

    typedef enum logic [2:0] {
        OP_PRD   = 3'd0,
        OP_NEW   = 3'd1,
        OP_UPD   = 3'd2,
        OP_XPOSE = 3'd3,
        OP_INV   = 3'd4,
        OP_CHI   = 3'd5
    } op_e;

    // Mapper select codes; the din mapper decodes the same values.
    localparam logic [3:0] Bca_IDLE  = 4'b0000;
    localparam logic [3:0] Bca_PRD   = 4'b1101;
    localparam logic [3:0] Bca_NEW   = 4'b1110;
    localparam logic [3:0] Bca_UPD   = 4'b1111;
    localparam logic [3:0] Bca_XPOSE = 4'b1001;
    localparam logic [3:0] Bca_INV   = 4'b1010;
    localparam logic [3:0] Bca_CHI   = 4'b1011;

    // Final sequence step and write window [WF, WL] per fixed-length op.
    // TRANSPOSE takes its final step and window end from the request length.
    localparam logic [3:0] LAST_PRD = 4'd5;
    localparam logic [3:0] LAST_NEW = 4'd6;
    localparam logic [3:0] LAST_UPD = 4'd7;
    localparam logic [3:0] LAST_INV = 4'd9;
    localparam logic [3:0] LAST_CHI = 4'd11;

    localparam logic [3:0] WF_PRD   = 4'd1;
    localparam logic [3:0] WF_NEW   = 4'd1;
    localparam logic [3:0] WF_UPD   = 4'd1;
    localparam logic [3:0] WF_XPOSE = 4'd1;
    localparam logic [3:0] WF_INV   = 4'd7;
    localparam logic [3:0] WF_CHI   = 4'd10;

    localparam logic [3:0] WL_PRD   = 4'd5;
    localparam logic [3:0] WL_NEW   = 4'd6;
    localparam logic [3:0] WL_UPD   = 4'd7;
    localparam logic [3:0] WL_INV   = 4'd9;
    localparam logic [3:0] WL_CHI   = 4'd11;

    // Cycles from a sequence step to its write strobe.
    localparam int D_STD   = 1;
    localparam int D_XPOSE = 2;
    localparam int D_MAX   = 2;

    typedef struct packed {
        logic       legal;
        logic [3:0] sel;
        logic [3:0] last;
        logic [3:0] wf;
        logic [3:0] wl;
    } op_cfg_t;

    function automatic op_cfg_t op_cfg(input logic [2:0] op);
        op_cfg_t c;
        c = '0;
        case (op)
            OP_PRD:   c = '{legal: 1'b1, sel: Bca_PRD,   last: LAST_PRD, wf: WF_PRD,   wl: WL_PRD};
            OP_NEW:   c = '{legal: 1'b1, sel: Bca_NEW,   last: LAST_NEW, wf: WF_NEW,   wl: WL_NEW};
            OP_UPD:   c = '{legal: 1'b1, sel: Bca_UPD,   last: LAST_UPD, wf: WF_UPD,   wl: WL_UPD};
            OP_XPOSE: c = '{legal: 1'b1, sel: Bca_XPOSE, last: 4'd0,     wf: WF_XPOSE, wl: 4'd0};
            OP_INV:   c = '{legal: 1'b1, sel: Bca_INV,   last: LAST_INV, wf: WF_INV,   wl: WL_INV};
            OP_CHI:   c = '{legal: 1'b1, sel: Bca_CHI,   last: LAST_CHI, wf: WF_CHI,   wl: WL_CHI};
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/b_cache_wr_seq_delay_line.sv
// seq_delay_line: fixed-depth shift register with every stage exposed.
// Carries the write strobe/address/last flag from the sequencing stage to the
// B-cache write port; the parent picks the tap matching the op's latency.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset, clears every stage
//   din    - word entering stage 0
//   taps   - taps[i] is din delayed by i+1 cycles
module seq_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [W-1:0]              din,
    output logic [DEPTH-1:0][W-1:0]   taps
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/b_cache_wr_seq.sv
// b_cache_wr_seq: write sequencer for the B-cache input path.
// Takes one operation request at a time, steps the din mapper through it via
// B_cache_in_sel/seq_cnt_out, issues TB-buffer reads for transposes, and
// produces the B-cache write strobe/address aligned with the mapper output.
//
// state | meaning
// IDLE  | ready for a request; select and step counter at 0
// RUN   | seq_cnt_out stepping 1..LAST, select holds the op code
// DRAIN | seq_cnt_out = 0, waiting D cycles for the last write to emerge
//
// Ports:
//   clk, sys_rst_n            - clock, asynchronous active-low reset
//   req_vld/req_rdy           - request handshake (req_rdy high only in IDLE)
//   req_op, req_base_addr,
//   req_src_addr, req_len     - request fields, latched at the handshake
//   B_cache_in_sel,
//   seq_cnt_out               - din mapper steering
//   tb_rd_en, tb_rd_addr      - TB-buffer read port (transpose only)
//   B_cache_wea, B_cache_addra- B-cache write port
//   done                      - pulse with the final write
//   err                       - pulse one cycle after an illegal request
module b_cache_wr_seq
    import b_cache_wr_seq_pkg::*;
#(
    parameter int SEQ_CNT_DW = 10,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  sys_rst_n,
    input  logic                  req_vld,
    input  logic [2:0]            req_op,
    input  logic [ADDR_W-1:0]     req_base_addr,
    input  logic [ADDR_W-1:0]     req_src_addr,
    input  logic [SEQ_CNT_DW-1:0] req_len,
    output logic                  req_rdy,
    output logic [3:0]            B_cache_in_sel,
    output logic [SEQ_CNT_DW-1:0] seq_cnt_out,
    output logic                  tb_rd_en,
    output logic [ADDR_W-1:0]     tb_rd_addr,
    output logic                  B_cache_wea,
    output logic [ADDR_W-1:0]     B_cache_addra,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    localparam int DLW = ADDR_W + 2;

    state_e                state_q, state_d;
    logic [SEQ_CNT_DW-1:0] seq_q, seq_d;
    logic [3:0]            sel_q, sel_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic                  err_q, err_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [SEQ_CNT_DW-1:0] wf_q, wf_d;
    logic [SEQ_CNT_DW-1:0] wl_q, wl_d;
    logic [SEQ_CNT_DW-1:0] last_q, last_d;
    logic                  deep_q, deep_d;
    logic [1:0]            drain_q, drain_d;

    op_cfg_t               cfg;
    logic                  is_xpose;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            seq_q     <= '0;
            sel_q     <= Bca_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
            base_q    <= '0;
            wf_q      <= '0;
            wl_q      <= '0;
            last_q    <= '0;
            deep_q    <= 1'b0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            sel_q     <= sel_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
            base_q    <= base_d;
            wf_q      <= wf_d;
            wl_q      <= wl_d;
            last_q    <= last_d;
            deep_q    <= deep_d;
            drain_q   <= drain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        sel_d     = sel_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        err_d     = 1'b0;
        base_d    = base_q;
        wf_d      = wf_q;
        wl_d      = wl_q;
        last_d    = last_q;
        deep_d    = deep_q;
        drain_d   = drain_q;
        cfg       = op_cfg(req_op);
        is_xpose  = (req_op == OP_XPOSE);

        case (state_q)
            S_IDLE: begin
                seq_d   = '0;
                sel_d   = Bca_IDLE;
                rd_en_d = 1'b0;
                if (req_vld) begin
                    // A zero-length transpose has nothing to write, so it is
                    // rejected the same way as an unknown opcode.
                    if (!cfg.legal || (is_xpose && req_len == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        seq_d     = SEQ_CNT_DW'(1);
                        sel_d     = cfg.sel;
                        base_d    = req_base_addr;
                        wf_d      = SEQ_CNT_DW'(cfg.wf);
                        wl_d      = is_xpose ? req_len : SEQ_CNT_DW'(cfg.wl);
                        last_d    = is_xpose ? req_len : SEQ_CNT_DW'(cfg.last);
                        deep_d    = is_xpose;
                        rd_en_d   = is_xpose;
                        rd_addr_d = req_src_addr;
                    end
                end
            end
            S_RUN: begin
                if (seq_q == last_q) begin
                    state_d   = S_DRAIN;
                    seq_d     = '0;
                    rd_en_d   = 1'b0;
                    rd_addr_d = '0;
                    drain_d   = deep_q ? 2'(D_XPOSE - 1) : 2'(D_STD - 1);
                end else begin
                    seq_d     = seq_q + SEQ_CNT_DW'(1);
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_IDLE;
                    sel_d   = Bca_IDLE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write stage: derived from the registered step, then delayed by D.
    logic                  wea_s;
    logic                  last_s;
    logic [SEQ_CNT_DW-1:0] off_s;
    logic [ADDR_W-1:0]     addr_s;
    logic [D_MAX-1:0][DLW-1:0] taps;
    logic [DLW-1:0]        tap_sel;

    always_comb begin
        wea_s  = (state_q == S_RUN) && (seq_q >= wf_q) && (seq_q <= wl_q);
        last_s = (state_q == S_RUN) && (seq_q == last_q);
        off_s  = seq_q - wf_q;
        addr_s = wea_s ? (base_q + ADDR_W'(off_s)) : '0;
    end

    seq_delay_line #(
        .W     (DLW),
        .DEPTH (D_MAX)
    ) u_delay (
        .clk   (clk),
        .rst_n (sys_rst_n),
        .din   ({wea_s, last_s, addr_s}),
        .taps  (taps)
    );

    assign tap_sel = deep_q ? taps[D_XPOSE-1] : taps[D_STD-1];

    assign req_rdy        = (state_q == S_IDLE);
    assign B_cache_in_sel = sel_q;
    assign seq_cnt_out    = seq_q;
    assign tb_rd_en       = rd_en_q;
    assign tb_rd_addr     = rd_addr_q;
    assign err            = err_q;
    assign B_cache_wea    = tap_sel[DLW-1];
    assign done           = tap_sel[DLW-2];
    assign B_cache_addra  = tap_sel[ADDR_W-1:0];

endmodule

// File: tb/tb_b_cache_wr_seq.sv
module tb_b_cache_wr_seq;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        req_vld = 1'b0;
    logic [2:0]  req_op = '0;
    logic [7:0]  req_base_addr = '0;
    logic [7:0]  req_src_addr = '0;
    logic [9:0]  req_len = '0;
    logic        req_rdy;
    logic [3:0]  B_cache_in_sel;
    logic [9:0]  seq_cnt_out;
    logic        tb_rd_en;
    logic [7:0]  tb_rd_addr;
    logic        B_cache_wea;
    logic [7:0]  B_cache_addra;
    logic        done;
    logic        err;

    b_cache_wr_seq #(.SEQ_CNT_DW(10), .ADDR_W(8)) dut (
        .clk            (clk),
        .sys_rst_n      (sys_rst_n),
        .req_vld        (req_vld),
        .req_op         (req_op),
        .req_base_addr  (req_base_addr),
        .req_src_addr   (req_src_addr),
        .req_len        (req_len),
        .req_rdy        (req_rdy),
        .B_cache_in_sel (B_cache_in_sel),
        .seq_cnt_out    (seq_cnt_out),
        .tb_rd_en       (tb_rd_en),
        .tb_rd_addr     (tb_rd_addr),
        .B_cache_wea    (B_cache_wea),
        .B_cache_addra  (B_cache_addra),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int done_after_rst = 0;
    bit count_done = 1'b0;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t wr_q[$];
    exp_t rd_q[$];
    exp_t sq_q[$];
    int   er_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference behaviour for one accepted request, written independently.
    task automatic push_exp(input logic [2:0] op, input logic [7:0] base, input logic [7:0] src,
                            input logic [9:0] len, input int t);
        int last, wf, d;
        logic [3:0] sel;
        bit legal;
        legal = 1'b1;
        last = 0; wf = 1; sel = 4'h0;
        case (op)
            3'd0: begin last = 5;   wf = 1;  sel = 4'b1101; end
            3'd1: begin last = 6;   wf = 1;  sel = 4'b1110; end
            3'd2: begin last = 7;   wf = 1;  sel = 4'b1111; end
            3'd3: begin last = int'(len); wf = 1; sel = 4'b1001; end
            3'd4: begin last = 9;   wf = 7;  sel = 4'b1010; end
            3'd5: begin last = 11;  wf = 10; sel = 4'b1011; end
            default: legal = 1'b0;
        endcase
        if (op == 3'd3 && len == 10'd0) legal = 1'b0;
        d = (op == 3'd3) ? 2 : 1;
        if (!legal) begin
            er_q.push_back(t + 1);
        end else begin
            for (int k = 1; k <= last; k++) begin
                sq_q.push_back('{cyc: t + k, a: 32'(k), b: 32'(sel)});
                if (op == 3'd3)
                    rd_q.push_back('{cyc: t + k, a: 32'(8'(src + 8'(k - 1))), b: 32'd0});
                if (k >= wf)
                    wr_q.push_back('{cyc: t + k + d, a: 32'(8'(base + 8'(k - wf))),
                                     b: 32'(k == last)});
            end
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sys_rst_n) begin
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                e = wr_q.pop_front();
                chk("wr_missed", cyc, e.cyc);
            end
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                e = wr_q.pop_front();
                chk("wr_wea", B_cache_wea, 1);
                chk("wr_addr", B_cache_addra, e.a);
                chk("wr_done", done, e.b);
            end else if (B_cache_wea || done) begin
                chk("wr_spurious", {B_cache_wea, done}, 0);
            end

            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                e = rd_q.pop_front();
                chk("rd_missed", cyc, e.cyc);
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                e = rd_q.pop_front();
                chk("rd_en", tb_rd_en, 1);
                chk("rd_addr", tb_rd_addr, e.a);
            end else if (tb_rd_en) begin
                chk("rd_spurious", tb_rd_en, 0);
            end

            while (sq_q.size() > 0 && sq_q[0].cyc < cyc) begin
                e = sq_q.pop_front();
                chk("seq_missed", cyc, e.cyc);
            end
            if (sq_q.size() > 0 && sq_q[0].cyc == cyc) begin
                e = sq_q.pop_front();
                chk("seq_cnt", seq_cnt_out, e.a);
                chk("seq_sel", B_cache_in_sel, e.b);
            end else if (seq_cnt_out != 0) begin
                chk("seq_spurious", seq_cnt_out, 0);
            end

            if (er_q.size() > 0 && er_q[0] == cyc) begin
                void'(er_q.pop_front());
                chk("err_pulse", err, 1);
            end else if (err) begin
                chk("err_spurious", err, 0);
            end

            if (count_done && done) done_after_rst++;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] base, input logic [7:0] src,
                         input logic [9:0] len, output int t);
        t = -1;
        @(negedge clk);
        req_op = op;
        req_base_addr = base;
        req_src_addr = src;
        req_len = len;
        req_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (req_rdy) begin
                t = cyc;
                push_exp(op, base, src, len, t);
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            chk("accept_timeout", req_rdy, 1);
            req_vld = 1'b0;
        end else begin
            @(posedge clk);
            #1 req_vld = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int c);
        @(negedge clk);
        for (int i = 0; i < 500 && cyc < c; i++) @(negedge clk);
        chk("wait_sync", cyc, c);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        @(negedge clk);
        while (i < 200 && !(req_rdy && wr_q.size() == 0 && sq_q.size() == 0 &&
                            rd_q.size() == 0 && er_q.size() == 0)) begin
            @(negedge clk);
            i++;
        end
        chk("idle_timeout", i < 200, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t, t1, t2;

        #3;
        chk("rst_rdy", req_rdy, 1);
        chk("rst_sel", B_cache_in_sel, 0);
        chk("rst_seq", seq_cnt_out, 0);
        chk("rst_wea", B_cache_wea, 0);
        chk("rst_addra", B_cache_addra, 0);
        chk("rst_rd_en", tb_rd_en, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;

        // PRD, base 0x10
        issue(3'd0, 8'h10, 8'h00, 10'd0, t);
        wait_cyc(t + 6);
        chk("prd_rdy_busy", req_rdy, 0);
        wait_cyc(t + 7);
        chk("prd_rdy_back", req_rdy, 1);
        chk("prd_sel_idle", B_cache_in_sel, 0);

        // INV then CHI
        issue(3'd4, 8'h20, 8'h00, 10'd0, t);
        wait_idle();
        issue(3'd5, 8'h30, 8'h00, 10'd0, t);
        wait_idle();
        issue(3'd1, 8'h70, 8'h00, 10'd0, t);
        wait_idle();

        // TRANSPOSE len 3, src 0x40, base 0xFE (address wrap)
        issue(3'd3, 8'hFE, 8'h40, 10'd3, t);
        wait_cyc(t + 5);
        chk("xp_sel_drain", B_cache_in_sel, 4'b1001);
        chk("xp_rdy_drain", req_rdy, 0);
        wait_cyc(t + 6);
        chk("xp_sel_idle", B_cache_in_sel, 0);
        chk("xp_rdy_back", req_rdy, 1);

        // Illegal opcode and zero-length transpose
        issue(3'd6, 8'h55, 8'h00, 10'd0, t);
        wait_cyc(t + 1);
        chk("ill_rdy", req_rdy, 1);
        chk("ill_sel", B_cache_in_sel, 0);
        issue(3'd3, 8'h55, 8'h11, 10'd0, t);
        wait_cyc(t + 1);
        chk("xp0_rdy", req_rdy, 1);
        chk("xp0_rd_en", tb_rd_en, 0);
        wait_idle();

        // UPD then a queued PRD with busy-time req_vld pulses, then reset
        issue(3'd2, 8'h50, 8'h00, 10'd0, t1);
        req_op = 3'd0;
        req_base_addr = 8'h60;
        wait_cyc(t1 + 2);
        req_vld = 1'b1;
        wait_cyc(t1 + 3);
        req_vld = 1'b0;
        wait_cyc(t1 + 5);
        req_vld = 1'b1;
        issue(3'd0, 8'h60, 8'h00, 10'd0, t2);
        chk("b2b_accept", t2, t1 + 9);
        wait_cyc(t2 + 3);
        sys_rst_n = 1'b0;
        #1;
        chk("arst_rdy", req_rdy, 1);
        chk("arst_sel", B_cache_in_sel, 0);
        chk("arst_seq", seq_cnt_out, 0);
        chk("arst_wea", B_cache_wea, 0);
        chk("arst_addra", B_cache_addra, 0);
        chk("arst_rd_en", tb_rd_en, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        wr_q.delete();
        rd_q.delete();
        sq_q.delete();
        er_q.delete();
        count_done = 1'b1;
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_done_after_rst", done_after_rst, 0);
        chk("post_rst_rdy", req_rdy, 1);

        chk("wr_q_empty", wr_q.size(), 0);
        chk("sq_q_empty", sq_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("er_q_empty", er_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/b_cache_wr_seq.md
# b_cache_wr_seq

Write sequencer for the B-cache input path. It accepts one operation request at a time: PRD, NEW or UPD nonlinear Jacobian load, transpose copy, 2×2 inverse, or chi. For the duration of the operation it drives the `B_cache_in_sel` / `seq_cnt_out` pair that steers the B-cache din mapper. It then produces the matching B-cache write strobe and address, aligned to the mapper's registered `B_cache_din`. For transposes it also issues the TB-buffer reads that feed the mapper.

## Interface
- `SEQ_CNT_DW`, 10: width of `seq_cnt_out` and `req_len`.
- `ADDR_W`, 8: B-cache and TB-buffer address width.
- `clk` in 1: single clock, rising edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `req_vld` in 1: operation request valid.
- `req_op` in 3: 0 PRD, 1 NEW, 2 UPD, 3 TRANSPOSE, 4 INV, 5 CHI; 6–7 illegal.
- `req_base_addr` in ADDR_W: first B-cache write address.
- `req_src_addr` in ADDR_W: first TB read address (TRANSPOSE only).
- `req_len` in SEQ_CNT_DW: row count (TRANSPOSE only).
- `req_rdy` out 1: high only in IDLE.
- `B_cache_in_sel` out 4: mapper select.
- `seq_cnt_out` out SEQ_CNT_DW: mapper step counter.
- `tb_rd_en` out 1: TB-buffer read strobe.
- `tb_rd_addr` out ADDR_W: TB-buffer read address.
- `B_cache_wea` out 1: B-cache write enable.
- `B_cache_addra` out ADDR_W: B-cache write address.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle illegal-request pulse.

## Operation
- Select codes per op: PRD 4'b1101, NEW 4'b1110, UPD 4'b1111, TRANSPOSE 4'b1001, INV 4'b1010, CHI 4'b1011. IDLE drives 4'b0000.
- Per-op `LAST` (final seq value) and write window `[WF, WL]`:
  - PRD: 5, [1,5]
  - NEW: 6, [1,6]
  - UPD: 7, [1,7]
  - INV: 9, [7,9]
  - CHI: 11, [10,11]
  - TRANSPOSE: `req_len`, [1,`req_len`]
- Pipeline depth `D`: 1 for all ops except TRANSPOSE, where `D` = 2 (TB read latency plus mapper register).
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on a handshake (`req_vld & req_rdy`) with a legal op. Op, base, src and len are latched at the handshake.
  - RUN: `seq_cnt_out` counts 1..LAST. RUN→DRAIN after LAST.
  - DRAIN: lasts `D` cycles. `seq_cnt_out` = 0 and `B_cache_in_sel` holds the op code. DRAIN→IDLE afterwards.
- Write for step k (WF ≤ k ≤ WL): `B_cache_wea` = 1 and `B_cache_addra` = base + (k − WF), mod 2^ADDR_W. The strobe is issued `D` cycles after `seq_cnt_out` = k.
- TRANSPOSE: `tb_rd_en` = 1 and `tb_rd_addr` = src + (k − 1), mod 2^ADDR_W, in the same cycle as `seq_cnt_out` = k.
- `done` pulses in the cycle of the final write.
- Illegal op, or TRANSPOSE with `req_len` = 0: the request is consumed, `err` pulses the next cycle, the FSM stays in IDLE and no `done` is issued.
- `req_vld` while busy is ignored; the requester holds it until `req_rdy` is high.

## Timing
- Reset (asynchronous assert): every output is 0 except `req_rdy`, which is 1. State goes to IDLE.
- Reset mid-operation aborts the operation with no `done` and no further writes.
- Handshake in cycle T: `seq_cnt_out` = k in cycle T+k. The last write and `done` are in cycle T+LAST+D. `req_rdy` = 1 from T+LAST+D+1.
- Back-to-back accept is possible at T+LAST+D+1. `B_cache_in_sel` returns to 0 in that cycle unless a new request is accepted then; the new op's select appears at T+LAST+D+2.
- All outputs are registered. There is no combinational path from `req_*` to any output except `req_rdy`, which is a state decode.

## Structure
- Shared package holds:
  - the op encodings;
  - the Bca_* select constants (shared with the din mapper);
  - the LAST/WF/WL constants per op;
  - the `D` values.
- One sub-module, `seq_delay_line`: a parameterised-depth shift register that carries {wea, addr, last} from the RUN stage to the write outputs. It is instantiated once, with the tap chosen by the latched `D`.

## Test plan
- PRD, base 0x10, handshake at T: `seq_cnt_out` 1..5 at T+1..T+5; `B_cache_wea` at T+2..T+6 with `B_cache_addra` 0x10..0x14; `done` at T+6; `req_rdy` at T+7.
- INV, base 0x20: `seq_cnt_out` 1..9; writes only at T+8..T+10 to 0x20..0x22; `done` at T+10. CHI, base 0x30: writes at T+11 and T+12 to 0x30, 0x31.
- TRANSPOSE, len 3, src 0x40, base 0xFE: `tb_rd_en` at T+1..T+3 with `tb_rd_addr` 0x40..0x42; `B_cache_wea` at T+3..T+5 with addresses 0xFE, 0xFF, 0x00; `B_cache_in_sel` = 4'b1001 through T+5; `done` at T+5.
- `req_op` = 6, and separately TRANSPOSE with len 0: `err` at T+1; no `B_cache_wea`, no `done`; `req_rdy` stays 1.
- UPD with `req_vld` held high and a second request queued: second handshake at T+9; `req_vld` pulses in between are ignored. Then `sys_rst_n` low at T+12: all outputs 0 asynchronously, and there is no `done` after release.
